front_panel_sequencer: RTL and testbench
========================================

// Module: front_panel_sequencer
// PURPOSE
//  Front-panel command sequencer between the debounced hex keypad and the target memory bus.
//  Hex keys build an address or data value; EXAMINE / DEPOSIT / NEXT run single bus reads or writes.
//  Bus commands are accepted only while the CPU is stopped.
//  Drives the 24-bit {addr,data} display word consumed by the seven-segment driver.
// PARAMETERS
//  ADDR_W   16   address register / bus address width (multiple of 4)
//  DATA_W   8    data register / bus data width (multiple of 4)
//  TIMEOUT  255  cycles bus_req may stay high without bus_ack before abort (>=1)
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  rst        in   1               synchronous reset, active-high
//  stopped    in   1               CPU halted; bus commands permitted only when 1
//  key_valid  in   1               one-cycle pulse, hex key pressed
//  key_code   in   4               hex value of pressed key, valid with key_valid
//  cmd_addr   in   1               pulse: select address entry mode
//  cmd_exam   in   1               pulse: read mem[addr]
//  cmd_dep    in   1               pulse: write data to mem[addr]
//  cmd_next   in   1               pulse: addr <= addr+1, then read
//  bus_req    out  1               bus request, held until ack or timeout
//  bus_we     out  1               1 = write, 0 = read; stable while bus_req=1
//  bus_addr   out  ADDR_W          address; stable while bus_req=1
//  bus_wdata  out  DATA_W          write data; stable while bus_req=1
//  bus_rdata  in   DATA_W          read data, sampled on the cycle bus_ack=1
//  bus_ack    in   1               transfer complete, honoured only while bus_req=1
//  disp       out  ADDR_W+DATA_W   {addr, data}
//  dispValid  out  1               0 while a bus transfer is in flight
//  err        out  1               one-cycle pulse: command rejected or bus timeout
// BEHAVIOUR
//  Reset values: addr=0, data=0, mode=ADDR, state=IDLE, bus_req=0, bus_we=0, err=0,
//   dispValid=1, disp=0, timeout counter=0.
//  State machine states: IDLE, READ, WRITE. Entry mode bit: ADDR or DATA.
//  IDLE: at most one event per cycle. Priority: cmd_exam > cmd_dep > cmd_next > cmd_addr > key_valid.
//   Lower-priority events on the same cycle are dropped silently.
//  key_valid, mode ADDR: addr <= {addr[ADDR_W-5:0], key_code}.
//  key_valid, mode DATA: data <= {data[DATA_W-5:0], key_code}. Accepted regardless of stopped.
//  cmd_addr: mode <= ADDR. Registers are not changed.
//  cmd_exam/cmd_dep/cmd_next with stopped=1, event on cycle N:
//   - bus_req=1 from cycle N+1.
//   - cmd_exam -> READ at addr.
//   - cmd_dep -> WRITE of data at addr.
//   - cmd_next: addr <= addr+1 mod 2^ADDR_W at N, then READ at the new addr (0xFFFF wraps to 0x0000).
//  Same commands with stopped=0: err=1 on N+1. No bus activity, no register change.
//  READ/WRITE: bus_req held 1, dispValid=0, counter increments each cycle.
//   bus_ack=1 on cycle M:
//   - READ: data <= bus_rdata, mode <= DATA.
//   - bus_req=0 and state=IDLE on M+1. A command is accepted no earlier than M+1.
//   Counter reaching TIMEOUT without ack:
//   - bus_req=0, err=1 on the next cycle, data unchanged, state=IDLE.
//  All key and cmd events outside IDLE are ignored, and err pulses.
//  stopped falling mid-transfer does not abort; the transfer runs to ack or timeout.
//  rst mid-transfer: all outputs return to reset values on the next edge. bus_req drops without ack.
//  disp and dispValid are driven straight from registers, with no extra latency.
// CONFIGURATION
//  FPS_AUTO_INC_EN defined: after an acked WRITE, addr <= addr+1 (wraps), data <= 0, mode <= DATA.
//   This allows consecutive deposits.
//  FPS_AUTO_INC_EN undefined: after a WRITE, addr, data and mode are unchanged.
// TESTING
//  1. reset; keys 1,2,3,4 -> addr=0x1234, disp=0x123400, no bus_req
//  2. stopped=1, cmd_exam, ack 3 cycles later with rdata=0xA5
//     -> bus_req high 3 cycles, we=0, disp=0x1234A5, mode DATA
//  3. stopped=0, cmd_dep -> err single pulse, bus_req stays 0, disp unchanged
//  4. TIMEOUT=4, cmd_exam, never ack -> bus_req high 4 cycles, err pulse, data unchanged, IDLE
//  5. addr=0xFFFF, cmd_next with ack -> bus_addr=0x0000, read completes
//  6. mode DATA, keys 5,A, cmd_dep, ack -> we=1, wdata=0x5A
//     -> with FPS_AUTO_INC_EN: addr+1, data=0; without: addr, data unchanged

Source files
------------

// File: rtl/front_panel_sequencer.sv
// Front-panel sequencer: hex keypad entry of address/data and single EXAMINE/DEPOSIT/NEXT bus cycles.
// Optional FPS_AUTO_INC_EN: an acked write advances addr, clears data and stays in data entry mode.
module front_panel_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stopped,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  input  logic                     cmd_addr,
  input  logic                     cmd_exam,
  input  logic                     cmd_dep,
  input  logic                     cmd_next,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     bus_ack,
  output logic [ADDR_W+DATA_W-1:0] disp,
  output logic                     dispValid,
  output logic                     err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {MODE_ADDR, MODE_DATA} mode_t;

  state_t            state, state_nxt;
  mode_t             mode, mode_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] data, data_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              err_q, err_nxt;
  logic              we_q, we_nxt;
  logic              any_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode  <= MODE_ADDR;
      addr  <= '0;
      data  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      addr  <= addr_nxt;
      data  <= data_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      we_q  <= we_nxt;
    end
  end

  assign any_evt = key_valid | cmd_addr | cmd_exam | cmd_dep | cmd_next;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    addr_nxt  = addr;
    data_nxt  = data;
    cnt_nxt   = '0;
    err_nxt   = 1'b0;
    we_nxt    = we_q;
    case (state)
      IDLE: begin
        // One event per cycle, highest priority first; the rest are dropped
        if (cmd_exam) begin
          if (stopped) begin
            state_nxt = READ;
            we_nxt    = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (cmd_dep) begin
          if (stopped) begin
            state_nxt = WRITE;
            we_nxt    = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (cmd_next) begin
          if (stopped) begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = READ;
            we_nxt    = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (cmd_addr) begin
          mode_nxt = MODE_ADDR;
        end else if (key_valid) begin
          if (mode == MODE_ADDR) addr_nxt = {addr[ADDR_W-5:0], key_code};
          else                   data_nxt = {data[DATA_W-5:0], key_code};
        end
      end
      READ, WRITE: begin
        err_nxt = any_evt;
        if (bus_ack) begin
          state_nxt = IDLE;
          we_nxt    = 1'b0;
          if (state == READ) begin
            data_nxt = bus_rdata;
            mode_nxt = MODE_DATA;
          end else begin
`ifdef FPS_AUTO_INC_EN
            addr_nxt = addr + ADDR_W'(1);
            data_nxt = '0;
            mode_nxt = MODE_DATA;
`else
            addr_nxt = addr;
`endif
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Abort: drop the request, keep data, report the failure
          state_nxt = IDLE;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        we_nxt    = 1'b0;
      end
    endcase
  end

  assign bus_req   = (state != IDLE);
  assign dispValid = (state == IDLE);
  assign bus_we    = we_q;
  assign bus_addr  = addr;
  assign bus_wdata = data;
  assign disp      = {addr, data};
  assign err       = err_q;

endmodule

// File: tb/tb_front_panel_sequencer.sv
// Randomized self-checking bench for front_panel_sequencer against a transaction-level model.
module tb_front_panel_sequencer;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int TO    = 4;
  localparam int AMASK = (1 << AW) - 1;
  localparam int DMASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stopped = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = '0;
  logic          cmd_addr = 1'b0;
  logic          cmd_exam = 1'b0;
  logic          cmd_dep = 1'b0;
  logic          cmd_next = 1'b0;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic [AW+DW-1:0] disp;
  logic          dispValid;
  logic          err;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: register contents and entry mode (0 = address, 1 = data)
  int m_addr = 0;
  int m_data = 0;
  bit m_mode = 0;

  front_panel_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stopped(stopped), .key_valid(key_valid), .key_code(key_code),
    .cmd_addr(cmd_addr), .cmd_exam(cmd_exam), .cmd_dep(cmd_dep), .cmd_next(cmd_next),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .disp(disp), .dispValid(dispValid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input bit expErr);
    checkOutput({tag, "_disp"}, 32'(disp), 32'((m_addr << DW) | m_data));
    checkOutput({tag, "_req"}, 32'(bus_req), 0);
    checkOutput({tag, "_dvalid"}, 32'(dispValid), 1);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
  endtask

  task automatic clearInputs();
    key_valid = 1'b0;
    cmd_addr  = 1'b0;
    cmd_exam  = 1'b0;
    cmd_dep   = 1'b0;
    cmd_next  = 1'b0;
    bus_ack   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    m_addr = 0;
    m_data = 0;
    m_mode = 0;
    checkState("reset", 0);
    checkOutput("reset_we", 32'(bus_we), 0);
    rst = 1'b0;
  endtask

  // Key press in IDLE; a stray ack with no request must have no effect
  task automatic doKey(input logic [3:0] k, input bit noise);
    key_valid = 1'b1;
    key_code  = k;
    if (noise) begin
      bus_ack   = 1'b1;
      bus_rdata = DW'($urandom);
      stopped   = 1'($urandom);
    end
    @(negedge clk);
    clearInputs();
    if (m_mode == 0) m_addr = (m_addr * 16 + int'(k)) & AMASK;
    else             m_data = (m_data * 16 + int'(k)) & DMASK;
    checkState("key", 0);
  endtask

  task automatic doAddrCmd(input bit noiseKey);
    cmd_addr = 1'b1;
    if (noiseKey) begin
      key_valid = 1'b1;
      key_code  = 4'($urandom);
    end
    @(negedge clk);
    clearInputs();
    m_mode = 0;
    checkState("cmdaddr", 0);
  endtask

  // kind: 0 exam, 1 deposit, 2 next. ackDelay >= TO means the bus never answers.
  task automatic applyStimulus(input int kind, input bit stp, input int ackDelay,
                               input logic [DW-1:0] rdata, input bit lower, input bit poke);
    int  tgt;
    bit  acked;
    bit  pk;
    bit  isWrite;
    tgt     = (kind == 2) ? ((m_addr + 1) & AMASK) : m_addr;
    isWrite = (kind == 1);
    pk      = poke && (ackDelay >= 1);
    stopped = stp;
    cmd_exam = (kind == 0);
    cmd_dep  = (kind == 1) || (lower && kind < 1);
    cmd_next = (kind == 2) || (lower && kind < 2);
    if (lower) begin
      cmd_addr  = 1'b1;
      key_valid = 1'b1;
      key_code  = 4'($urandom);
    end
    @(negedge clk);
    clearInputs();
    if (!stp) begin
      checkState("reject", 1);
      @(negedge clk);
      checkState("reject_after", 0);
      return;
    end
    m_addr = tgt;
    acked  = 0;
    for (int i = 0; i < TO; i++) begin
      checkOutput("busy_req", 32'(bus_req), 1);
      checkOutput("busy_we", 32'(bus_we), 32'(isWrite));
      checkOutput("busy_addr", 32'(bus_addr), 32'(m_addr));
      checkOutput("busy_dvalid", 32'(dispValid), 0);
      checkOutput("busy_err", 32'(err), 32'(pk && i == 1));
      if (isWrite) checkOutput("busy_wdata", 32'(bus_wdata), 32'(m_data));
      if (i == 0) begin
        stopped = 1'($urandom);
        if (pk) begin
          key_valid = 1'b1;
          key_code  = 4'($urandom);
          cmd_exam  = 1'($urandom);
        end
      end
      if (i == ackDelay) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        acked     = 1;
      end
      @(negedge clk);
      clearInputs();
      stopped = 1'b1;
      if (acked) break;
    end
    if (acked) begin
      if (!isWrite) begin
        m_data = int'(rdata);
        m_mode = 1;
      end else begin
`ifdef FPS_AUTO_INC_EN
        m_addr = (m_addr + 1) & AMASK;
        m_data = 0;
        m_mode = 1;
`endif
      end
      checkState("done", 0);
    end else begin
      checkState("timeout", 1);
    end
  endtask

  task automatic doResetMid();
    stopped  = 1'b1;
    cmd_exam = 1'b1;
    @(negedge clk);
    clearInputs();
    checkOutput("rstmid_req", 32'(bus_req), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_addr = 0;
    m_data = 0;
    m_mode = 0;
    checkState("rstmid", 0);
    checkOutput("rstmid_we", 32'(bus_we), 0);
  endtask

  initial begin
    int r;
    $display("[TB] start");
    doReset();

    doKey(4'h1, 0); doKey(4'h2, 0); doKey(4'h3, 0); doKey(4'h4, 0);
    checkOutput("t1_disp", 32'(disp), 32'h123400);

    applyStimulus(0, 1, 2, 8'hA5, 0, 0);
    checkOutput("t2_disp", 32'(disp), 32'h1234A5);

    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkOutput("t3_disp", 32'(disp), 32'h1234A5);

    applyStimulus(0, 1, TO, 8'h77, 0, 0);
    checkOutput("t4_disp", 32'(disp), 32'h1234A5);

    doAddrCmd(0);
    doKey(4'hF, 0); doKey(4'hF, 0); doKey(4'hF, 0); doKey(4'hF, 0);
    applyStimulus(2, 1, 1, 8'h3C, 0, 0);
    checkOutput("t5_disp", 32'(disp), 32'h00003C);

    doKey(4'h5, 0); doKey(4'hA, 0);
    applyStimulus(1, 1, 1, 8'h00, 0, 0);
`ifdef FPS_AUTO_INC_EN
    checkOutput("t6_disp", 32'(disp), 32'h000100);
`else
    checkOutput("t6_disp", 32'(disp), 32'h00005A);
`endif

    doResetMid();

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       doKey(4'($urandom), 1'($urandom));
      else if (r < 10) doAddrCmd(1'($urandom));
      else if (r < 19) applyStimulus($urandom_range(0, 2), ($urandom_range(0, 4) != 0),
                                     $urandom_range(0, TO), DW'($urandom),
                                     1'($urandom), 1'($urandom));
      else             doResetMid();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
